// File: rtl/alimentador_contador.sv
// alimentador_contador: FIFO-buffered word feeder for the ones-counter (start/pronto handshake, valid/ready result register)
// Ports: clk_i, reset_ni (sync, active-low) | in_valid_i/in_data_i/in_ready_o: source stream into the FIFO
//        a_o/start_o/pronto_i/resultado_i: counter interface | res_valid_o/res_data_o/res_ready_i: result output
//        fifo_count_o: queued words | busy_o: dispatch in progress | timeout_err_o: sticky abort (DISPATCH_TIMEOUT_EN only)
// Optional feature macro: DISPATCH_TIMEOUT_EN (abort a dispatch after TIMEOUT_CYCLES WAIT cycles without pronto)
module alimentador_contador #(
  parameter int DEPTH          = 4,
  parameter int DATA_W         = 16,
  parameter int RES_W          = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       in_valid_i,
  input  logic [DATA_W-1:0]          in_data_i,
  output logic                       in_ready_o,
  output logic [DATA_W-1:0]          a_o,
  output logic                       start_o,
  input  logic                       pronto_i,
  input  logic [RES_W-1:0]           resultado_i,
  output logic                       res_valid_o,
  output logic [RES_W-1:0]           res_data_o,
  input  logic                       res_ready_i,
  output logic [$clog2(DEPTH):0]     fifo_count_o,
`ifdef DISPATCH_TIMEOUT_EN
  output logic                       timeout_err_o,
`endif
  output logic                       busy_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, START, BLANK, WAIT} state_e;
  state_e              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_q, rd_q;
  logic [CW-1:0]       cnt_q;
  logic [DATA_W-1:0]   a_q, a_d;
  logic                res_valid_q, res_valid_d;
  logic [RES_W-1:0]    res_data_q, res_data_d;
  logic                push, pop, capture, expire;
`ifdef DISPATCH_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                terr_q, terr_d;
  // The counter covers WAIT cycles 0..TIMEOUT_CYCLES-1; the last of them aborts.
  assign expire = state_q == WAIT && !pronto_i && tmr_q == TW'(TIMEOUT_CYCLES - 1);
  assign timeout_err_o = terr_q;
  always_comb begin
    tmr_d = state_q == BLANK ? '0 : state_q == WAIT ? tmr_q + 1'b1 : tmr_q;
    terr_d = terr_q || expire;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      tmr_q <= '0;
      terr_q <= 1'b0;
    end else begin
      tmr_q <= tmr_d;
      terr_q <= terr_d;
    end
  end
`else
  assign expire = 1'b0;
`endif
  // No push-through when full: in_ready ignores a same-cycle pop.
  assign in_ready_o = cnt_q != CW'(DEPTH);
  assign push = in_valid_i && in_ready_o;
  // Dispatch only when the result register is (or is becoming) empty so a capture never overwrites.
  assign pop = state_q == IDLE && cnt_q != '0 && (!res_valid_q || res_ready_i);
  assign capture = state_q == WAIT && pronto_i;
  assign a_o = a_q;
  assign start_o = state_q == START;
  assign busy_o = state_q != IDLE;
  assign res_valid_o = res_valid_q;
  assign res_data_o = res_data_q;
  assign fifo_count_o = cnt_q;
  always_comb begin
    state_d = state_q;
    a_d = a_q;
    res_valid_d = res_valid_q;
    res_data_d = res_data_q;
    state_d = pop ? START : state_q == START ? BLANK : state_q == BLANK ? WAIT : (capture || expire) ? IDLE : state_q;
    a_d = pop ? mem_q[rd_q] : a_q;
    res_valid_d = capture || (res_valid_q && !res_ready_i);
    res_data_d = capture ? resultado_i : res_data_q;
  end
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      a_q <= '0;
      res_valid_q <= 1'b0;
      res_data_q <= '0;
    end else begin
      state_q <= state_d;
      wr_q <= push ? wr_q + 1'b1 : wr_q;
      rd_q <= pop ? rd_q + 1'b1 : rd_q;
      cnt_q <= cnt_q + CW'(push) - CW'(pop);
      a_q <= a_d;
      res_valid_q <= res_valid_d;
      res_data_q <= res_data_d;
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_q] <= in_data_i;
  end
endmodule

// File: tb/tb_alimentador_contador.sv
// tb_alimentador_contador: directed + randomized bench with a transaction-level reference model
module tb_alimentador_contador;
  localparam int DEPTH = 4;
  localparam int DW = 16;
  localparam int RW = 5;
  localparam int CW = 3;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_ni = 1'b0;
  logic in_valid_i = 1'b0;
  logic [DW-1:0] in_data_i = '0;
  logic pronto_i = 1'b0;
  logic [RW-1:0] resultado_i = '0;
  logic res_ready_i = 1'b0;
  logic in_ready_o, start_o, res_valid_o, busy_o;
  logic [DW-1:0] a_o;
  logic [RW-1:0] res_data_o;
  logic [CW-1:0] fifo_count_o;
`ifdef DISPATCH_TIMEOUT_EN
  logic timeout_err_o;
`endif
  alimentador_contador #(.DEPTH(DEPTH), .DATA_W(DW), .RES_W(RW), .TIMEOUT_CYCLES(64)) dut (
    .clk_i(clk), .reset_ni(reset_ni), .in_valid_i(in_valid_i), .in_data_i(in_data_i),
    .in_ready_o(in_ready_o), .a_o(a_o), .start_o(start_o), .pronto_i(pronto_i),
    .resultado_i(resultado_i), .res_valid_o(res_valid_o), .res_data_o(res_data_o),
    .res_ready_i(res_ready_i), .fifo_count_o(fifo_count_o),
`ifdef DISPATCH_TIMEOUT_EN
    .timeout_err_o(timeout_err_o),
`endif
    .busy_o(busy_o)
  );
  int npass = 0;
  int ntot = 0;
  logic [DW-1:0] words[$];
  int exp_res[$];
  int taken[$];
  int m_cnt = 0, m_age = 0, k = 0, lat = 4, max_cnt = 0;
  bit m_busy = 0, m_rv = 0, m_terr = 0, armed = 0, saw_full = 0;
  logic [DW-1:0] m_a = '0;
  logic [RW-1:0] m_rd = '0, inflight = '0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask
  // One clock: inputs already driven; model advances on the edge; outputs sampled 1 time unit later.
  task automatic cyc();
    bit push_now, take_now, pr_now, go, rst_now;
    logic [DW-1:0] pd;
    rst_now = !reset_ni;
    push_now = in_valid_i && in_ready_o;
    pd = in_data_i;
    take_now = res_valid_o && res_ready_i;
    pr_now = pronto_i;
    go = !rst_now && !m_busy && m_cnt != 0 && (!m_rv || res_ready_i);
    if (take_now && !rst_now) begin
      chk("res_take", res_data_o, exp_res.size() != 0 ? exp_res[0] : 32'hDEAD);
      taken.push_back(int'(res_data_o));
      if (exp_res.size() != 0) void'(exp_res.pop_front());
    end
    @(posedge clk);
    #1;
    pronto_i = 1'b0;
    if (rst_now) begin
      words.delete();
      exp_res.delete();
      m_cnt = 0; m_busy = 0; m_rv = 0; m_terr = 0; m_a = '0; m_rd = '0; armed = 0; m_age = 0;
    end else begin
      if (push_now) begin
        words.push_back(pd);
        m_cnt++;
      end
      if (pr_now) begin
        m_rv = 1; m_rd = inflight; exp_res.push_back(int'(inflight)); m_busy = 0; armed = 0;
      end else if (take_now) m_rv = 0;
      if (m_busy) m_age++;
`ifdef DISPATCH_TIMEOUT_EN
      if (m_busy && m_age == 66) begin
        m_busy = 0; m_terr = 1;
      end
`endif
      if (go) begin
        if (words.size() != 0) m_a = words.pop_front();
        else m_a = 'x;
        m_cnt--; m_busy = 1; m_age = 0;
        inflight = RW'($countones(m_a));
        armed = lat != 0; k = lat;
      end else if (armed) begin
        k--;
        pronto_i = k == 0;
      end
    end
    resultado_i = pronto_i ? inflight : RW'($urandom);
    chk("start", start_o, go);
    chk("a", a_o, m_a);
    chk("fifo_count", fifo_count_o, m_cnt);
    chk("in_ready", in_ready_o, m_cnt < DEPTH);
    chk("busy", busy_o, m_busy);
    chk("res_valid", res_valid_o, m_rv);
    chk("res_data", res_data_o, m_rd);
`ifdef DISPATCH_TIMEOUT_EN
    chk("timeout_err", timeout_err_o, m_terr);
`endif
    if (int'(fifo_count_o) > max_cnt) max_cnt = int'(fifo_count_o);
    if (!in_ready_o) saw_full = 1;
  endtask
  task automatic push(input logic [DW-1:0] w);
    int n = 0;
    bit ok = 0;
    in_data_i = w;
    in_valid_i = 1'b1;
    do begin
      ok = in_ready_o;
      cyc();
      n++;
    end while (!ok && n < 200);
    in_valid_i = 1'b0;
    chk("push_bound", ok, 1);
  endtask
  task automatic wait_res(input int lim);
    int n = 0;
    while (!res_valid_o && n < lim) begin
      cyc();
      n++;
    end
    chk("wait_res", res_valid_o, 1);
  endtask
  task automatic settle(input int lim);
    int n = 0;
    while ((busy_o || res_valid_o || fifo_count_o != 0) && n < lim) begin
      cyc();
      n++;
    end
    chk("settle", busy_o || res_valid_o || fifo_count_o != 0, 0);
  endtask
  initial begin
    int exp3[6] = '{0, 1, 2, 8, 16, 5};
    int n;
    reset_ni = 1'b0;
    repeat (2) cyc();
    reset_ni = 1'b1;
    cyc();
    chk("rst_ready", in_ready_o, 1);
    // single all-ones word, slow counter, consumer initially stalled
    lat = 17;
    res_ready_i = 1'b0;
    push(16'hFFFF);
    wait_res(40);
    chk("t2_data", res_data_o, 16);
    repeat (5) cyc();
    chk("t2_hold", res_valid_o, 1);
    res_ready_i = 1'b1;
    cyc();
    chk("t2_drain", res_valid_o, 0);
    // back-to-back burst overflowing the FIFO
    lat = 6;
    taken.delete();
    max_cnt = 0;
    saw_full = 0;
    push(16'h0000); push(16'h0001); push(16'h8001);
    push(16'h00FF); push(16'hFFFF); push(16'h1234);
    settle(300);
    chk("t3_count", taken.size(), 6);
    for (int i = 0; i < 6; i++) chk("t3_order", i < taken.size() ? taken[i] : -1, exp3[i]);
    chk("t3_max", max_cnt, DEPTH);
    chk("t3_full", saw_full, 1);
    // pending result blocks dispatch until the consumer takes it
    lat = 3;
    res_ready_i = 1'b0;
    push(16'h0007);
    push(16'h0003);
    wait_res(40);
    repeat (10) cyc();
    chk("t4_idle", busy_o, 0);
    chk("t4_queued", fifo_count_o, 1);
    res_ready_i = 1'b1;
    cyc();
    chk("t4_start", start_o, 1);
    chk("t4_drained", res_valid_o, 0);
    settle(100);
    // reset while waiting for pronto
    lat = 20;
    push(16'h00F0);
    push(16'h0F00);
    n = 0;
    while (!(m_busy && m_age >= 3) && n < 50) begin
      cyc();
      n++;
    end
    chk("t5_inwait", busy_o, 1);
    reset_ni = 1'b0;
    cyc();
    reset_ni = 1'b1;
    repeat (30) cyc();
    chk("t5_rv", res_valid_o, 0);
    chk("t5_cnt", fifo_count_o, 0);
    chk("t5_start", start_o, 0);
    // randomized traffic with a 3-cycle reset in the middle
    for (int i = 0; i < 400; i++) begin
      reset_ni = !(i >= 200 && i < 203);
      in_valid_i = 1'($urandom);
      in_data_i = DW'($urandom);
      res_ready_i = ($urandom % 4) != 0;
      lat = 2 + int'($urandom % 8);
      cyc();
      if (i == 202) begin
        chk("t1_cnt", fifo_count_o, 0);
        chk("t1_ready", in_ready_o, 1);
        chk("t1_busy", busy_o, 0);
      end
    end
    in_valid_i = 1'b0;
    res_ready_i = 1'b1;
    settle(200);
`ifdef DISPATCH_TIMEOUT_EN
    lat = 0;
    push(16'h0101);
    push(16'h0303);
    n = 0;
    while (!m_terr && n < 200) begin
      cyc();
      n++;
    end
    chk("t6_terr", timeout_err_o, 1);
    chk("t6_idle", busy_o, 0);
    lat = 3;
    wait_res(40);
    chk("t6_next", res_data_o, 4);
    settle(100);
    chk("t6_sticky", timeout_err_o, 1);
`endif
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
